// File: rtl/peecc_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peecc_uart_pkg
// Description : Shared definitions for the statistics UART transmitter:
//               sequencer state encoding, default packet sync byte and the
//               baud divisor helper.
// Revision    : 1.0 - initial release
// ============================================================================
package peecc_uart_pkg;

    // Packet sequencer states. LOAD has no encoding of its own: the byte
    // selection happens in the same cycle the sequencer enters START.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } tx_state_e;

    localparam logic [7:0] c_sync_byte_default = 8'hA5;

    // Clock cycles per UART bit (integer divide; callers need a result >= 2).
    function automatic int clks_per_bit(input int freq_hz, input int baud);
        return freq_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 byte serializer with its own baud counter. A load pulse
//               starts a frame on the next cycle; a new load on the last
//               cycle of the stop bit chains the next frame with no gap.
// Ports       : clk, rst       - system clock, synchronous active-high reset
//               load, data_in  - start a frame carrying data_in
//               serial         - UART line (idles high), straight from a flop
//               bit_tick       - last cycle of the current bit
//               byte_done      - last cycle of the stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic       serial,
    output logic       bit_tick,
    output logic       byte_done
);

    localparam int                 c_cnt_w     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_baud_one  = c_cnt_w'(1);
    localparam logic [3:0]         c_last_bit  = 4'd9;

    logic [c_cnt_w-1:0] r_baud_cnt_q, w_baud_cnt_d;
    logic [3:0]         r_bit_cnt_q,  w_bit_cnt_d;
    logic [9:0]         r_shift_q,    w_shift_d;
    logic               r_active_q,   w_active_d;

    assign bit_tick  = r_active_q && (r_baud_cnt_q == c_baud_last);
    assign byte_done = bit_tick && (r_bit_cnt_q == c_last_bit);
    assign serial    = r_shift_q[0];

    // The frame {stop, data, start} shifts out LSB first; ones fill in from
    // the top so the line rests high once the stop bit has gone out.
    always_comb begin
        w_baud_cnt_d = r_baud_cnt_q;
        w_bit_cnt_d  = r_bit_cnt_q;
        w_shift_d    = r_shift_q;
        w_active_d   = r_active_q;
        if (load) begin
            w_shift_d    = {1'b1, data_in, 1'b0};
            w_baud_cnt_d = '0;
            w_bit_cnt_d  = '0;
            w_active_d   = 1'b1;
        end else if (r_active_q) begin
            if (bit_tick) begin
                w_baud_cnt_d = '0;
                w_shift_d    = {1'b1, r_shift_q[9:1]};
                if (r_bit_cnt_q == c_last_bit) begin
                    w_active_d  = 1'b0;
                    w_bit_cnt_d = '0;
                end else begin
                    w_bit_cnt_d = r_bit_cnt_q + 4'd1;
                end
            end else begin
                w_baud_cnt_d = r_baud_cnt_q + c_baud_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud_cnt_q <= '0;
            r_bit_cnt_q  <= '0;
            r_shift_q    <= '1;
            r_active_q   <= 1'b0;
        end else begin
            r_baud_cnt_q <= w_baud_cnt_d;
            r_bit_cnt_q  <= w_bit_cnt_d;
            r_shift_q    <= w_shift_d;
            r_active_q   <= w_active_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_stats_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_stats_tx
// Description : Packet sequencer for the statistics UART responder. On
//               start_tx it snapshots stage_id/stats_in and sends
//               SYNC, {5'b0,stage}, payload (word 0 first, MSB byte first),
//               XOR checksum of the payload, then pulses txFinish.
// Ports       : clk, rst   - system clock, synchronous active-high reset
//               start_tx   - packet request (ignored unless idle)
//               stage_id   - stage tag sent in byte 1
//               stats_in   - NUM_WORDS x WORD_W statistics vector
//               tx_serial  - UART line, idles high
//               tx_busy    - packet in flight
//               txFinish   - one-cycle completion pulse
//               overrun    - sticky: request seen while busy
// Revision    : 1.0 - initial release
// ============================================================================
module uart_stats_tx
    import peecc_uart_pkg::*;
#(
    parameter int         CLK_FREQ_HZ = 50_000_000,
    parameter int         BAUD        = 115_200,
    parameter int         NUM_WORDS   = 4,
    parameter int         WORD_W      = 32,
    parameter logic [7:0] SYNC_BYTE   = c_sync_byte_default
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_tx,
    input  logic [2:0]                  stage_id,
    input  logic [NUM_WORDS*WORD_W-1:0] stats_in,
    output logic                        tx_serial,
    output logic                        tx_busy,
    output logic                        txFinish,
    output logic                        overrun
);

    localparam int c_clks_per_bit   = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int c_bytes_per_word = WORD_W / 8;
    localparam int c_payload_bytes  = NUM_WORDS * c_bytes_per_word;
    localparam int c_num_bytes      = c_payload_bytes + 3;
    localparam int c_idx_w          = $clog2(c_num_bytes);

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_num_bytes - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

    tx_state_e                   r_state_q,    w_state_d;
    logic [2:0]                  r_bit_idx_q,  w_bit_idx_d;
    logic [c_idx_w-1:0]          r_byte_idx_q, w_byte_idx_d;
    logic [NUM_WORDS*WORD_W-1:0] r_stats_q,    w_stats_d;
    logic [2:0]                  r_stage_q,    w_stage_d;
    logic [7:0]                  r_csum_q,     w_csum_d;
    logic                        r_busy_q,     w_busy_d;
    logic                        r_finish_q,   w_finish_d;
    logic                        r_overrun_q,  w_overrun_d;

    logic               w_load;
    logic [7:0]         w_load_byte;
    logic [c_idx_w-1:0] w_next_idx;
    logic [7:0]         w_next_byte;
    logic               w_next_is_payload;
    logic               w_serial;
    logic               w_bit_tick;
    logic               w_byte_done;

    uart_tx_byte #(
        .CLKS_PER_BIT (c_clks_per_bit)
    ) u_tx_byte (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .data_in   (w_load_byte),
        .serial    (w_serial),
        .bit_tick  (w_bit_tick),
        .byte_done (w_byte_done)
    );

    // Byte that follows the one currently on the line. Byte 0 (SYNC) is a
    // constant and is loaded directly at accept, so it never appears here.
    assign w_next_idx = r_byte_idx_q + c_idx_one;

    always_comb begin
        w_next_byte       = 8'h00;
        w_next_is_payload = 1'b0;
        if (w_next_idx == c_idx_one) begin
            w_next_byte = {5'b0, r_stage_q};
        end else if (w_next_idx == c_last_idx) begin
            w_next_byte = r_csum_q;
        end
        for (int k = 0; k < c_payload_bytes; k++) begin
            if (w_next_idx == c_idx_w'(k + 2)) begin
                w_next_byte = r_stats_q[(k / c_bytes_per_word) * WORD_W + WORD_W - 8
                                        - 8 * (k % c_bytes_per_word) +: 8];
                w_next_is_payload = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_bit_idx_d  = r_bit_idx_q;
        w_byte_idx_d = r_byte_idx_q;
        w_stats_d    = r_stats_q;
        w_stage_d    = r_stage_q;
        w_csum_d     = r_csum_q;
        w_busy_d     = r_busy_q;
        w_finish_d   = 1'b0;
        // The DONE cycle has busy low, so a request there is simply dropped.
        w_overrun_d  = r_overrun_q | (start_tx & r_busy_q);
        w_load       = 1'b0;
        w_load_byte  = SYNC_BYTE;

        case (r_state_q)
            ST_IDLE: begin
                if (start_tx) begin
                    w_stats_d    = stats_in;
                    w_stage_d    = stage_id;
                    w_byte_idx_d = '0;
                    w_bit_idx_d  = '0;
                    w_csum_d     = '0;
                    w_load       = 1'b1;
                    w_load_byte  = SYNC_BYTE;
                    w_busy_d     = 1'b1;
                    w_state_d    = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_tick) begin
                    w_bit_idx_d = '0;
                    w_state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_tick) begin
                    if (r_bit_idx_q == 3'd7) begin
                        w_state_d = ST_STOP;
                    end else begin
                        w_bit_idx_d = r_bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_byte_done) begin
                    if (r_byte_idx_q < c_last_idx) begin
                        // Chain the next byte on the same edge so frames abut.
                        w_byte_idx_d = w_next_idx;
                        w_load       = 1'b1;
                        w_load_byte  = w_next_byte;
                        if (w_next_is_payload) begin
                            w_csum_d = r_csum_q ^ w_next_byte;
                        end
                        w_state_d    = ST_START;
                    end else begin
                        w_busy_d   = 1'b0;
                        w_finish_d = 1'b1;
                        w_state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_bit_idx_q  <= '0;
            r_byte_idx_q <= '0;
            r_stats_q    <= '0;
            r_stage_q    <= '0;
            r_csum_q     <= '0;
            r_busy_q     <= 1'b0;
            r_finish_q   <= 1'b0;
            r_overrun_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_bit_idx_q  <= w_bit_idx_d;
            r_byte_idx_q <= w_byte_idx_d;
            r_stats_q    <= w_stats_d;
            r_stage_q    <= w_stage_d;
            r_csum_q     <= w_csum_d;
            r_busy_q     <= w_busy_d;
            r_finish_q   <= w_finish_d;
            r_overrun_q  <= w_overrun_d;
        end
    end

    assign tx_serial = w_serial;
    assign tx_busy   = r_busy_q;
    assign txFinish  = r_finish_q;
    assign overrun   = r_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_stats_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_stats_tx
// Description : Self-checking bench for uart_stats_tx (CLKS_PER_BIT=4,
//               2 x 16-bit words, 7-byte packets). A packet-level model
//               predicts the line every cycle; a UART decoder recovers bytes
//               for comparison with hand-computed packets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_stats_tx;

    localparam int CLK_FREQ_HZ = 400;
    localparam int BAUD        = 100;
    localparam int CPB         = 4;
    localparam int NUM_WORDS   = 2;
    localparam int WORD_W      = 16;
    localparam int NB          = 7;
    localparam int PKT_CYC     = NB * 10 * CPB;

    typedef logic [7:0] pkt_t [NB];

    logic        clk = 1'b0;
    logic        rst;
    logic        start_tx;
    logic [2:0]  stage_id;
    logic [31:0] stats_in;
    wire         tx_serial;
    wire         tx_busy;
    wire         txFinish;
    wire         overrun;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_stats_tx #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD),
        .NUM_WORDS   (NUM_WORDS),
        .WORD_W      (WORD_W),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_tx  (start_tx),
        .stage_id  (stage_id),
        .stats_in  (stats_in),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .txFinish  (txFinish),
        .overrun   (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Packet contents straight from the packet definition.
    function automatic pkt_t make_pkt(input logic [2:0] st, input logic [31:0] s);
        pkt_t        p;
        logic [15:0] word;
        logic [7:0]  x;
        int          b;
        p[0] = 8'hA5;
        p[1] = {5'b0, st};
        b    = 2;
        x    = 8'h00;
        for (int w = 0; w < NUM_WORDS; w++) begin
            word = s[w*16 +: 16];
            p[b] = word[15:8]; x ^= p[b]; b++;
            p[b] = word[7:0];  x ^= p[b]; b++;
        end
        p[NB-1] = x;
        return p;
    endfunction

    // ---------------- packet-level model ----------------
    pkt_t m_bytes;
    int   m_t;
    bit   m_busy, m_fin, m_ovr, chk_en;

    function automatic logic line_at(input int t);
        int byte_n, pos;
        byte_n = t / (10 * CPB);
        pos    = (t % (10 * CPB)) / CPB;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return m_bytes[byte_n][pos-1];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_fin = 0; m_ovr = 0; m_t = 0; chk_en = 1;
        end else if (m_busy) begin
            if (start_tx) m_ovr = 1;
            m_t++;
            if (m_t == PKT_CYC) begin
                m_busy = 0;
                m_fin  = 1;
            end
        end else if (m_fin) begin
            m_fin = 0;
        end else if (start_tx) begin
            m_bytes = make_pkt(stage_id, stats_in);
            m_busy  = 1;
            m_t     = 0;
        end
    end

    always @(posedge clk) begin
        logic e_ser;
        #1;
        if (chk_en) begin
            e_ser = m_busy ? line_at(m_t) : 1'b1;
            n_tests++;
            if ({tx_serial, tx_busy, txFinish, overrun} !== {e_ser, m_busy, m_fin, m_ovr}) begin
                n_fail++;
                $display("FAIL cycle_check @%0t: serial/busy/finish/overrun got %b%b%b%b expected %b%b%b%b",
                         $time, tx_serial, tx_busy, txFinish, overrun, e_ser, m_busy, m_fin, m_ovr);
            end
        end
    end

    // ---------------- line decoder ----------------
    logic [7:0] rx_q[$];
    logic [7:0] rx_b;
    int         rx_frame_err = 0;

    always begin
        @(posedge clk);
        #1;
        if (chk_en && tx_serial === 1'b0) begin
            repeat (CPB + CPB/2) @(posedge clk);
            #1 rx_b[0] = tx_serial;
            for (int i = 1; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 rx_b[i] = tx_serial;
            end
            repeat (CPB) @(posedge clk);
            #1;
            if (tx_serial !== 1'b1) rx_frame_err++;
            rx_q.push_back(rx_b);
        end
    end

    task automatic check_rx(input pkt_t exp, input string tag);
        logic [7:0] got;
        check({tag, "_rx_count"}, rx_q.size(), NB);
        for (int i = 0; i < NB; i++) begin
            if (rx_q.size() > 0) got = rx_q.pop_front();
            else                 got = 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), got, exp[i]);
        end
        rx_q.delete();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic start_pkt(input logic [2:0] st, input logic [31:0] s);
        @(negedge clk);
        stage_id = st;
        stats_in = s;
        start_tx = 1'b1;
        @(negedge clk);
        start_tx = 1'b0;
        check("accept_busy", tx_busy, 1);
        check("accept_start_bit", tx_serial, 0);
    endtask

    // Returns on the txFinish cycle; lat counts cycles from the first busy cycle.
    task automatic wait_finish(input bit scramble, input bit poke, output int lat);
        int n;
        bit seen;
        n    = 0;
        seen = 0;
        while (!seen && n < PKT_CYC + 40) begin
            if (txFinish === 1'b1) begin
                seen = 1;
            end else begin
                start_tx = poke && (n == 100);
                if (scramble) begin
                    stats_in = $urandom;
                    stage_id = 3'($urandom);
                end
                @(negedge clk);
                n++;
            end
        end
        start_tx = 1'b0;
        lat = seen ? n : -1;
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL finish_timeout: no txFinish within %0d cycles", PKT_CYC + 40);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t        e1, e2, e3, e4, e5;
        int          lat;
        bit          seen;
        logic [31:0] tbl_stats [5];

        // Checksums: AB^CD^12^34=40, BE^EF^DE^AD=22, F0^F0^0F^0F=00,
        // 80^00^00^01=81, 00^00^FF^FF=00.
        e1 = '{8'hA5, 8'h05, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'h40};
        e2 = '{8'hA5, 8'h02, 8'hBE, 8'hEF, 8'hDE, 8'hAD, 8'h22};
        e3 = '{8'hA5, 8'h07, 8'hF0, 8'hF0, 8'h0F, 8'h0F, 8'h00};
        e4 = '{8'hA5, 8'h01, 8'h80, 8'h00, 8'h00, 8'h01, 8'h81};
        e5 = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
        tbl_stats = '{32'h0000_0001, 32'h8000_0000, 32'hCAFE_F00D, 32'h1357_9BDF, 32'hFFFF_FFFF};

        rst      = 1'b1;
        start_tx = 1'b0;
        stage_id = 3'd0;
        stats_in = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_serial", tx_serial, 1);
        check("reset_busy", tx_busy, 0);
        check("reset_finish", txFinish, 0);
        check("reset_overrun", overrun, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic packet
        start_pkt(3'd5, 32'h1234_ABCD);
        wait_finish(0, 0, lat);
        check("t1_latency", lat, PKT_CYC);
        check("t1_busy_at_finish", tx_busy, 0);
        check_rx(e1, "t1");
        @(negedge clk);
        check("t1_finish_width", txFinish, 0);
        check("t1_overrun", overrun, 0);

        // Inputs scrambled every cycle while in flight
        start_pkt(3'd2, 32'hDEAD_BEEF);
        wait_finish(1, 0, lat);
        check("t2_latency", lat, PKT_CYC);
        check_rx(e2, "t2");

        // Request mid-packet, then at and just after txFinish
        start_pkt(3'd7, 32'h0F0F_F0F0);
        wait_finish(0, 1, lat);
        check("t3_latency", lat, PKT_CYC);
        check("t3_overrun_set", overrun, 1);
        check_rx(e3, "t3");
        stage_id = 3'd1;
        stats_in = 32'h0001_8000;
        start_tx = 1'b1;
        @(negedge clk);
        check("t3_finish_cycle_ignored", tx_busy, 0);
        @(negedge clk);
        start_tx = 1'b0;
        check("t3_restart_busy", tx_busy, 1);
        wait_finish(0, 0, lat);
        check("t3b_latency", lat, PKT_CYC);
        check("t3_overrun_sticky", overrun, 1);
        check_rx(e4, "t3b");

        // Reset during byte 3
        start_pkt(3'd6, 32'h5555_AAAA);
        repeat (130) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t4_abort_serial", tx_serial, 1);
        check("t4_abort_busy", tx_busy, 0);
        check("t4_abort_overrun", overrun, 0);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < PKT_CYC + 40; i++) begin
            if (txFinish === 1'b1) seen = 1;
            @(negedge clk);
        end
        check("t4_no_finish", seen, 0);
        rx_q.delete();
        start_pkt(3'd4, 32'hFFFF_0000);
        wait_finish(0, 0, lat);
        check("t4_latency", lat, PKT_CYC);
        check_rx(e5, "t4");

        // Back-to-back, request two cycles after each txFinish
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            start_pkt(3'(p), tbl_stats[p]);
            wait_finish(0, 0, lat);
            check($sformatf("t5_latency%0d", p), lat, PKT_CYC);
            check_rx(make_pkt(3'(p), tbl_stats[p]), $sformatf("t5_pkt%0d", p));
        end
        check("t5_overrun", overrun, 0);
        check("rx_frame_errors", rx_frame_err, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
